ifetch_stage: RTL and testbench



---
 rtl/ifetch_stage.sv | 129 ++++++++++++
 tb/tb_ifetch_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// requests to instruction memory, buffers returned instructions in a small
// FIFO and presents the head (or a NOP bubble) to decode every cycle.
// Redirects from writeback flush the buffer and discard a stale response.
module ifetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PCPlus8,
   output logic        validF
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      DROP_RSP = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [31:0]        fetch_pc;
   logic [31:0]        issue_pc;
   logic [31:0]        instr_buf [DEPTH];
   logic [31:0]        pc_buf    [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     count_after;
   logic               empty;
   logic               pop;
   logic               push;
   logic               issue;

   // Buffer head presentation and the pop/push/occupancy bookkeeping.
   always_comb begin
      empty       = (count == '0);
      validF      = ~empty;
      InstrF      = empty ? NOP_INSTR : instr_buf[rd_ptr];
      PCPlus8     = (empty ? fetch_pc : pc_buf[rd_ptr]) + 32'd8;
      pop         = validF & ~stall & ~PCSrcW;
      // Only a response we still want is pushed; a redirect kills it.
      push        = (state == WAIT_RSP) & imem_rvalid & ~PCSrcW;
      count_after = {1'b0, count} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(push);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state: track whether the outstanding response is kept or dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            // A stray rvalid here is ignored.
            if (issue) state_next = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (PCSrcW)           state_next = imem_rvalid ? IDLE : DROP_RSP;
            else if (imem_rvalid) state_next = issue ? WAIT_RSP : IDLE;
         end
         DROP_RSP: begin
            if (imem_rvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: request when there will be room and nothing else is pending.
   always_comb begin
      imem_req  = ~reset & ~PCSrcW & (count_after < DEPTH_C) &
                  ((state == IDLE) | ((state == WAIT_RSP) & imem_rvalid));
      imem_addr = fetch_pc;
      issue     = imem_req & imem_gnt;
   end

   // Fetch PC: redirect target wins, otherwise advance on each accepted request.
   always_ff @(posedge clk) begin
      if (reset)       fetch_pc <= RESET_PC;
      else if (PCSrcW) fetch_pc <= ResultW & 32'hFFFF_FFFC;
      else if (issue)  fetch_pc <= fetch_pc + 32'd4;
   end

   // PC of the request in flight, paired with its response on push.
   always_ff @(posedge clk) begin
      if (issue) issue_pc <= fetch_pc;
   end

   // Buffer pointers and occupancy; redirect flush beats pop and push.
   always_ff @(posedge clk) begin
      if (reset || PCSrcW) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_after[CNT_W-1:0];
      end
   end

   // Buffer storage of {instr, pc} pairs.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_buf[wr_ptr] <= imem_rdata;
         pc_buf[wr_ptr]    <= issue_pc;
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: a behavioural instruction memory (data = addr+0x100)
// with configurable grant rate and response latency, directed scenarios and a
// randomized run checked against a program-order reference of the fetch stream.
module tb_ifetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        PCSrcW;
   logic [31:0] ResultW;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] InstrF;
   logic [31:0] PCPlus8;
   logic        validF;

   int checks = 0;
   int errors = 0;

   // memory model configuration and state
   int          gnt_pct   = 100;
   int          dly_min   = 0;
   int          dly_max   = 0;
   logic        pend      = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_dly  = 0;
   int          grant_cnt = 0;

   ifetch_stage #(
      .RESET_PC (RST_PC),
      .DEPTH    (2),
      .NOP_INSTR(NOP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .PCSrcW     (PCSrcW),
      .ResultW    (ResultW),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .InstrF     (InstrF),
      .PCPlus8    (PCPlus8),
      .validF     (validF)
   );

   always #5 clk = ~clk;

   // Drive memory-side inputs for the current cycle, then settle.
   task automatic mem_prep();
      imem_rvalid = pend && (pend_dly == 0);
      imem_rdata  = imem_rvalid ? (pend_addr + 32'h100) : $urandom();
      imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
      #1;
   endtask

   // Commit the cycle at the rising edge and update the memory model.
   task automatic advance();
      logic        g;
      logic        rv;
      logic [31:0] a;
      g  = imem_req & imem_gnt;
      rv = imem_rvalid;
      a  = imem_addr;
      @(posedge clk);
      if (rv) pend = 1'b0;
      else if (pend && pend_dly > 0) pend_dly--;
      if (g) begin
         pend      = 1'b1;
         pend_addr = a;
         pend_dly  = $urandom_range(dly_max, dly_min);
         grant_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; PCSrcW = 1'b0; ResultW = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      pend = 1'b0; pend_dly = 0; grant_cnt = 0;
      gnt_pct = 100; dly_min = 0; dly_max = 0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; PCSrcW = 1'b0; ResultW = 32'h0;
      gnt_pct = 0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      mem_prep();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", imem_req); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", validF); end
      checks++; if (InstrF !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", InstrF, NOP); end
      checks++; if (PCPlus8 !== RST_PC + 32'd8) begin errors++; $display("FAIL reset_pcplus8 got %h want %h", PCPlus8, RST_PC + 32'd8); end
      advance();
      reset = 1'b0;
      mem_prep();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got %0b want 1", imem_req); end
      checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_first_addr got %h want %h", imem_addr, RST_PC); end
      checks++; if (validF !== 1'b0) begin errors++; $display("FAIL reset_first_valid got %0b want 0", validF); end
      advance();
   endtask

   task automatic test_stream();
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_p8;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         mem_prep();
         e_valid = (k >= 2);
         e_instr = e_valid ? 32'h100 + 4 * (k - 2) : NOP;
         e_p8    = e_valid ? 4 * (k - 2) + 8 : 4 * k + 8;
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d got %0b want 1", k, imem_req); end
         checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr k=%0d got %h want %h", k, imem_addr, 32'(4 * k)); end
         checks++; if (validF !== e_valid) begin errors++; $display("FAIL stream_valid k=%0d got %0b want %0b", k, validF, e_valid); end
         checks++; if (InstrF !== e_instr) begin errors++; $display("FAIL stream_instr k=%0d got %h want %h", k, InstrF, e_instr); end
         checks++; if (PCPlus8 !== e_p8) begin errors++; $display("FAIL stream_pcplus8 k=%0d got %h want %h", k, PCPlus8, e_p8); end
         advance();
      end
   endtask

   task automatic test_stall();
      int consumed;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         stall = (k >= 2);
         mem_prep();
         if (k >= 2) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req k=%0d got %0b want 0", k, imem_req); end
            checks++; if (validF !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d got %0b want 1", k, validF); end
            checks++; if (InstrF !== 32'h100) begin errors++; $display("FAIL stall_head k=%0d got %h want %h", k, InstrF, 32'h100); end
         end
         advance();
      end
      stall = 1'b0;
      consumed = 0;
      for (int k = 0; k < 5; k++) begin
         mem_prep();
         checks++; if (validF !== 1'b1) begin errors++; $display("FAIL stall_release_valid k=%0d got %0b want 1", k, validF); end
         checks++; if (InstrF !== 32'h100 + 4 * consumed) begin errors++; $display("FAIL stall_release_instr k=%0d got %h want %h", k, InstrF, 32'h100 + 4 * consumed); end
         checks++; if (PCPlus8 !== 32'(4 * consumed + 8)) begin errors++; $display("FAIL stall_release_pcplus8 k=%0d got %h want %h", k, PCPlus8, 32'(4 * consumed + 8)); end
         if (validF) consumed++;
         advance();
      end
   endtask

   task automatic test_redirect_drop();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         dly_min = (k == 3) ? 2 : 0;
         dly_max = dly_min;
         PCSrcW  = (k == 4);
         ResultW = (k == 4) ? 32'h203 : $urandom();
         mem_prep();
         case (k)
            4: begin
               checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req_redirect got %0b want 0", imem_req); end
               checks++; if (InstrF !== 32'h108) begin errors++; $display("FAIL drop_head_before got %h want %h", InstrF, 32'h108); end
            end
            5, 6: begin
               checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req_wait k=%0d got %0b want 0", k, imem_req); end
               checks++; if (validF !== 1'b0) begin errors++; $display("FAIL drop_valid k=%0d got %0b want 0", k, validF); end
               checks++; if (InstrF !== NOP) begin errors++; $display("FAIL drop_instr k=%0d got %h want %h", k, InstrF, NOP); end
               checks++; if (PCPlus8 !== 32'h208) begin errors++; $display("FAIL drop_pcplus8 k=%0d got %h want %h", k, PCPlus8, 32'h208); end
            end
            7: begin
               checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_target_req got %0b want 1", imem_req); end
               checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL drop_target_addr got %h want %h", imem_addr, 32'h200); end
               checks++; if (validF !== 1'b0) begin errors++; $display("FAIL drop_valid7 got %0b want 0", validF); end
            end
            8: begin
               checks++; if (validF !== 1'b0) begin errors++; $display("FAIL drop_valid8 got %0b want 0", validF); end
            end
            9: begin
               checks++; if (validF !== 1'b1) begin errors++; $display("FAIL drop_valid9 got %0b want 1", validF); end
               checks++; if (InstrF !== 32'h300) begin errors++; $display("FAIL drop_target_instr got %h want %h", InstrF, 32'h300); end
               checks++; if (PCPlus8 !== 32'h208) begin errors++; $display("FAIL drop_target_pcplus8 got %h want %h", PCPlus8, 32'h208); end
            end
            default: ;
         endcase
         advance();
      end
      PCSrcW = 1'b0;
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         PCSrcW  = (k == 4);
         ResultW = (k == 4) ? 32'h400 : $urandom();
         mem_prep();
         case (k)
            4: begin
               checks++; if (imem_rvalid !== 1'b1 || validF !== 1'b1) begin errors++; $display("FAIL coinc_setup rvalid=%0b validF=%0b want 1 1", imem_rvalid, validF); end
               checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL coinc_req got %0b want 0", imem_req); end
            end
            5: begin
               checks++; if (validF !== 1'b0) begin errors++; $display("FAIL coinc_valid5 got %0b want 0", validF); end
               checks++; if (InstrF !== NOP) begin errors++; $display("FAIL coinc_instr5 got %h want %h", InstrF, NOP); end
               checks++; if (PCPlus8 !== 32'h408) begin errors++; $display("FAIL coinc_pcplus8_5 got %h want %h", PCPlus8, 32'h408); end
               checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL coinc_req5 got %0b want 1", imem_req); end
               checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL coinc_addr5 got %h want %h", imem_addr, 32'h400); end
            end
            6: begin
               checks++; if (validF !== 1'b0) begin errors++; $display("FAIL coinc_valid6 got %0b want 0", validF); end
               checks++; if (imem_addr !== 32'h404) begin errors++; $display("FAIL coinc_addr6 got %h want %h", imem_addr, 32'h404); end
            end
            7: begin
               checks++; if (InstrF !== 32'h500 || validF !== 1'b1) begin errors++; $display("FAIL coinc_instr7 got %h/%0b want %h/1", InstrF, validF, 32'h500); end
            end
            default: ;
         endcase
         advance();
      end
      PCSrcW = 1'b0;
   endtask

   task automatic test_gnt_wait();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         gnt_pct = (k < 4) ? 0 : 100;
         mem_prep();
         if (k <= 4) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL gntwait_req k=%0d got %0b want 1", k, imem_req); end
            checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL gntwait_addr k=%0d got %h want %h", k, imem_addr, RST_PC); end
         end
         if (k == 5) begin
            checks++; if (grant_cnt != 1) begin errors++; $display("FAIL gntwait_grants got %0d want 1", grant_cnt); end
            checks++; if (imem_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL gntwait_next_addr got %h want %h", imem_addr, RST_PC + 32'd4); end
         end
         if (k == 6) begin
            checks++; if (InstrF !== 32'h100 || validF !== 1'b1) begin errors++; $display("FAIL gntwait_instr6 got %h/%0b want %h/1", InstrF, validF, 32'h100); end
         end
         if (k == 7) begin
            checks++; if (InstrF !== 32'h104) begin errors++; $display("FAIL gntwait_instr7 got %h want %h", InstrF, 32'h104); end
         end
         advance();
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         dly_min = (k == 1) ? 1 : 0;
         dly_max = dly_min;
         reset   = (k == 2);
         mem_prep();
         if (k == 2) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req2 got %0b want 0", imem_req); end
         end
         if (k == 3) begin
            checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL midrst_stray_setup got %0b want 1", imem_rvalid); end
            checks++; if (validF !== 1'b0) begin errors++; $display("FAIL midrst_valid3 got %0b want 0", validF); end
            checks++; if (InstrF !== NOP) begin errors++; $display("FAIL midrst_instr3 got %h want %h", InstrF, NOP); end
            checks++; if (PCPlus8 !== RST_PC + 32'd8) begin errors++; $display("FAIL midrst_pcplus8_3 got %h want %h", PCPlus8, RST_PC + 32'd8); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL midrst_req3 got %0b@%h want 1@%h", imem_req, imem_addr, RST_PC); end
         end
         if (k == 4) begin
            checks++; if (validF !== 1'b0) begin errors++; $display("FAIL midrst_valid4 got %0b want 0", validF); end
            checks++; if (imem_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL midrst_addr4 got %h want %h", imem_addr, RST_PC + 32'd4); end
         end
         if (k == 5) begin
            checks++; if (InstrF !== 32'h100 || validF !== 1'b1) begin errors++; $display("FAIL midrst_instr5 got %h/%0b want %h/1", InstrF, validF, 32'h100); end
            checks++; if (PCPlus8 !== RST_PC + 32'd8) begin errors++; $display("FAIL midrst_pcplus8_5 got %h want %h", PCPlus8, RST_PC + 32'd8); end
         end
         advance();
      end
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] mf_pc;
      int          consumed;
      do_reset();
      gnt_pct = 60; dly_min = 0; dly_max = 3;
      exp_pc = RST_PC; mf_pc = RST_PC; consumed = 0;
      for (int k = 0; k < 600; k++) begin
         stall  = ($urandom_range(99, 0) < 30);
         PCSrcW = ($urandom_range(99, 0) < 5);
         if ($urandom_range(9, 0) == 0) ResultW = 32'hFFFF_FFF0 | $urandom_range(15, 0);
         else                           ResultW = $urandom();
         mem_prep();
         if (PCSrcW) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rand_req_on_redirect k=%0d got %0b want 0", k, imem_req); end
         end
         checks++; if (imem_req && pend && !imem_rvalid) begin errors++; $display("FAIL rand_outstanding k=%0d got req=1 with response pending want req=0", k); end
         if (imem_req) begin
            checks++; if (imem_addr !== mf_pc) begin errors++; $display("FAIL rand_addr k=%0d got %h want %h", k, imem_addr, mf_pc); end
         end
         if (validF) begin
            checks++; if (InstrF !== exp_pc + 32'h100) begin errors++; $display("FAIL rand_instr k=%0d got %h want %h", k, InstrF, exp_pc + 32'h100); end
            checks++; if (PCPlus8 !== exp_pc + 32'd8) begin errors++; $display("FAIL rand_pcplus8 k=%0d got %h want %h", k, PCPlus8, exp_pc + 32'd8); end
         end else begin
            checks++; if (InstrF !== NOP) begin errors++; $display("FAIL rand_bubble k=%0d got %h want %h", k, InstrF, NOP); end
            checks++; if (PCPlus8 !== mf_pc + 32'd8) begin errors++; $display("FAIL rand_bubble_pcplus8 k=%0d got %h want %h", k, PCPlus8, mf_pc + 32'd8); end
         end
         if (PCSrcW) begin
            exp_pc = ResultW & 32'hFFFF_FFFC;
            mf_pc  = ResultW & 32'hFFFF_FFFC;
         end else begin
            if (validF && !stall) begin
               exp_pc = exp_pc + 32'd4;
               consumed++;
            end
            if (imem_req && imem_gnt) mf_pc = mf_pc + 32'd4;
         end
         advance();
      end
      stall = 1'b0; PCSrcW = 1'b0;
      checks++; if (consumed < 40) begin errors++; $display("FAIL rand_progress got %0d instructions want at least 40", consumed); end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; PCSrcW = 1'b0; ResultW = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_rvalid();
      test_gnt_wait();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end

endmodule
